// File: rtl/i2c_pkg.sv
// Shared I2C definitions: bus widths plus the master, slave and transaction-arbiter state encodings.
package i2c_pkg;

   localparam int unsigned I2C_ADDR_W = 7;
   localparam int unsigned I2C_DATA_W = 8;

   typedef enum logic [2:0] {
      MST_IDLE,
      MST_START,
      MST_ADDR,
      MST_DATA,
      MST_ACK,
      MST_STOP
   } i2c_mst_state_t;

   typedef enum logic [1:0] {
      SLV_IDLE,
      SLV_ADDR,
      SLV_DATA,
      SLV_ACK
   } i2c_slv_state_t;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_ISSUE,
      ARB_WAIT,
      ARB_RESP
   } arb_state_t;

endpackage

// File: rtl/i2c_rr_picker.sv
// Combinational round-robin search: first valid requester at or after i_rr_ptr, wrapping at NUM_REQ.
module i2c_rr_picker #(
   parameter int unsigned NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         i_valid,
   input  logic [$clog2(NUM_REQ)-1:0] i_rr_ptr,
   output logic                       o_any_valid,
   output logic [$clog2(NUM_REQ)-1:0] o_grant
);

   localparam int unsigned PTR_W = $clog2(NUM_REQ);
   localparam int unsigned IDX_W = PTR_W + 1;

   logic [IDX_W-1:0] w_idx;

   // Walk offsets from farthest to nearest so the closest valid requester is the last one written.
   always_comb begin
      o_any_valid = 1'b0;
      o_grant     = '0;
      w_idx       = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_idx = {1'b0, i_rr_ptr} + IDX_W'(k);
         if (w_idx >= IDX_W'(NUM_REQ)) begin
            w_idx = w_idx - IDX_W'(NUM_REQ);
         end
         if (i_valid[w_idx[PTR_W-1:0]]) begin
            o_any_valid = 1'b1;
            o_grant     = w_idx[PTR_W-1:0];
         end
      end
   end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Shares one I2C master between NUM_REQ requesters, one single-byte transaction at a time,
// granting round-robin and returning a per-requester response (with timeout abort).
module i2c_txn_arbiter
   import i2c_pkg::*;
#(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req_valid,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic [NUM_REQ*I2C_ADDR_W-1:0]  req_addr,
   input  logic [NUM_REQ-1:0]             req_rw,
   input  logic [NUM_REQ*I2C_DATA_W-1:0]  req_wdata,
   output logic [NUM_REQ-1:0]             rsp_valid,
   output logic [I2C_DATA_W-1:0]          rsp_rdata,
   output logic                           rsp_err,
   output logic                           m_start,
   output logic [I2C_ADDR_W-1:0]          m_addr,
   output logic                           m_rw,
   output logic [I2C_DATA_W-1:0]          m_wdata,
   input  logic                           m_done,
   input  logic [I2C_DATA_W-1:0]          m_rdata
);

   localparam int unsigned PTR_W = $clog2(NUM_REQ);
   localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES);

   arb_state_t            r_state;
   logic [PTR_W-1:0]      r_rr_ptr;
   logic [PTR_W-1:0]      r_grant;
   logic [TMR_W-1:0]      r_timer;
   logic [I2C_ADDR_W-1:0] r_addr;
   logic                  r_rw;
   logic [I2C_DATA_W-1:0] r_wdata;
   logic [I2C_DATA_W-1:0] r_rdata;
   logic                  r_err;

   arb_state_t            w_state_nxt;
   logic [PTR_W-1:0]      w_rr_ptr_nxt;
   logic [PTR_W-1:0]      w_grant_nxt;
   logic [TMR_W-1:0]      w_timer_nxt;
   logic [I2C_ADDR_W-1:0] w_addr_nxt;
   logic                  w_rw_nxt;
   logic [I2C_DATA_W-1:0] w_wdata_nxt;
   logic [I2C_DATA_W-1:0] w_rdata_nxt;
   logic                  w_err_nxt;

   logic                  w_any_valid;
   logic [PTR_W-1:0]      w_pick;

   i2c_rr_picker #(
      .NUM_REQ (NUM_REQ)
   ) u_picker (
      .i_valid     (req_valid),
      .i_rr_ptr    (r_rr_ptr),
      .o_any_valid (w_any_valid),
      .o_grant     (w_pick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ARB_IDLE;
         r_rr_ptr <= '0;
         r_grant  <= '0;
         r_timer  <= '0;
         r_addr   <= '0;
         r_rw     <= 1'b0;
         r_wdata  <= '0;
         r_rdata  <= '0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_rr_ptr <= w_rr_ptr_nxt;
         r_grant  <= w_grant_nxt;
         r_timer  <= w_timer_nxt;
         r_addr   <= w_addr_nxt;
         r_rw     <= w_rw_nxt;
         r_wdata  <= w_wdata_nxt;
         r_rdata  <= w_rdata_nxt;
         r_err    <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_rr_ptr_nxt = r_rr_ptr;
      w_grant_nxt  = r_grant;
      w_timer_nxt  = r_timer;
      w_addr_nxt   = r_addr;
      w_rw_nxt     = r_rw;
      w_wdata_nxt  = r_wdata;
      w_rdata_nxt  = r_rdata;
      w_err_nxt    = r_err;
      req_ready    = '0;
      rsp_valid    = '0;
      m_start      = 1'b0;

      unique case (r_state)
         ARB_IDLE: begin
            if (w_any_valid) begin
               for (int i = 0; i < NUM_REQ; i++) begin
                  if (w_pick == PTR_W'(i)) begin
                     req_ready[i] = 1'b1;
                     w_addr_nxt   = req_addr[i*I2C_ADDR_W +: I2C_ADDR_W];
                     w_rw_nxt     = req_rw[i];
                     w_wdata_nxt  = req_wdata[i*I2C_DATA_W +: I2C_DATA_W];
                  end
               end
               w_grant_nxt = w_pick;
               w_state_nxt = ARB_ISSUE;
            end
         end

         ARB_ISSUE: begin
            m_start     = 1'b1;
            w_timer_nxt = '0;
            w_state_nxt = ARB_WAIT;
         end

         ARB_WAIT: begin
            w_timer_nxt = r_timer + TMR_W'(1);
            // A completion on the timeout cycle still counts as success.
            if (m_done) begin
               w_rdata_nxt = r_rw ? '0 : m_rdata;
               w_err_nxt   = 1'b0;
               w_state_nxt = ARB_RESP;
            end else if (r_timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
               w_rdata_nxt = '0;
               w_err_nxt   = 1'b1;
               w_state_nxt = ARB_RESP;
            end
         end

         ARB_RESP: begin
            for (int i = 0; i < NUM_REQ; i++) begin
               if (r_grant == PTR_W'(i)) begin
                  rsp_valid[i] = 1'b1;
               end
            end
            w_rr_ptr_nxt = (r_grant == PTR_W'(NUM_REQ - 1)) ? '0 : r_grant + PTR_W'(1);
            w_state_nxt  = ARB_IDLE;
         end

         default: begin
            w_state_nxt = ARB_IDLE;
         end
      endcase
   end

   assign rsp_rdata = (r_state == ARB_RESP) ? r_rdata : '0;
   assign rsp_err   = (r_state == ARB_RESP) ? r_err : 1'b0;
   assign m_addr    = r_addr;
   assign m_rw      = r_rw;
   assign m_wdata   = r_wdata;

endmodule
